// File: rtl/pong_pkg.sv
// Shared constants for the pong game core: coordinate widths, top-state and
// tick-phase encodings, and ball direction encodings.
package pong_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [1:0] PH_P0 = 2'd0;
  localparam logic [1:0] PH_P1 = 2'd1;
  localparam logic [1:0] PH_P2 = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/pot_to_paddle.sv
// Combinational pot-to-paddle mapping: x2 scale, deadzone removal, clamp so the
// paddle stays fully on screen. Registered by the parent.
module pot_to_paddle
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned PAD_H    = 50,
  parameter int unsigned DEADZONE = 41
)(
  input  logic [7:0]     pot,
  output logic [Y_W-1:0] pad_y
);

  localparam logic [Y_W-1:0] PAD_MAX = Y_W'(SCREEN_H - PAD_H);

  logic [Y_W-1:0] scaled;
  logic [Y_W-1:0] above;

  assign scaled = Y_W'({pot, 1'b0});
  assign above  = scaled - Y_W'(DEADZONE);
  assign pad_y  = (scaled < Y_W'(DEADZONE)) ? '0 :
                  (above > PAD_MAX)         ? PAD_MAX : above;

endmodule

// File: rtl/pong_game_engine.sv
// Two-player pong core: paddle tracking, per-tick ball physics, scoring and the
// serve/play/point/over sequence. Optional macro PONG_SPEEDUP_EN makes each
// paddle hit speed the ball up (saturating at 7).
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 10,
  parameter int unsigned PAD_W       = 10,
  parameter int unsigned PAD_H       = 50,
  parameter int unsigned LEFT_PAD_X  = 40,
  parameter int unsigned RIGHT_PAD_X = 600,
  parameter int unsigned DEADZONE    = 41,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned BASE_SPEED  = 2
)(
  input  logic           board_clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           start,
  input  logic [7:0]     pot_left,
  input  logic [7:0]     pot_right,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic [Y_W-1:0] pad_left_y,
  output logic [Y_W-1:0] pad_right_y,
  output logic [3:0]     score_left,
  output logic [3:0]     score_right,
  output logic [2:0]     game_state,
  output logic           busy
);

  localparam int unsigned    CNT_W    = $clog2(SERVE_TICKS + 1);
  localparam logic [X_W-1:0] CENTRE_X = X_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0] CENTRE_Y = Y_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]     WIN      = 4'(WIN_SCORE);

  logic [2:0]       state;
  logic [1:0]       phase;
  logic             dir_x, dir_y;
  logic             scorer_left;
  logic [CNT_W-1:0] serve_cnt;
  logic [3:0]       speed;

  logic [Y_W-1:0] pad_left_nxt, pad_right_nxt;
  logic [Y_W-1:0] ball_cy;
  logic [X_W-1:0] speed_x;
  logic [Y_W-1:0] speed_y;
  logic           hit_left_p1, hit_right_p1, hit_p1;
  logic           goal_left_p1, goal_right_p1, wall_p1;
  logic           point_wins;

  assign game_state = state;

  pot_to_paddle #(.SCREEN_H(SCREEN_H), .PAD_H(PAD_H), .DEADZONE(DEADZONE))
    u_pad_left  (.pot(pot_left),  .pad_y(pad_left_nxt));
  pot_to_paddle #(.SCREEN_H(SCREEN_H), .PAD_H(PAD_H), .DEADZONE(DEADZONE))
    u_pad_right (.pot(pot_right), .pad_y(pad_right_nxt));

  function automatic logic y_covered(input logic [Y_W-1:0] cy, input logic [Y_W-1:0] pad);
    return (cy >= pad) && (cy < pad + Y_W'(PAD_H));
  endfunction

`ifdef PONG_SPEEDUP_EN
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'd7) ? 4'd7 : s + 4'd1;
  endfunction

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset)
      speed <= 4'(BASE_SPEED);
    else if (state == ST_SERVE)
      speed <= 4'(BASE_SPEED);
    else if (busy && phase == PH_P1 && state == ST_PLAY && hit_p1)
      speed <= sat_inc(speed);
  end
`else
  assign speed = 4'(BASE_SPEED);
`endif

  assign speed_x = X_W'(speed);
  assign speed_y = Y_W'(speed);
  assign ball_cy = ball_y + Y_W'(BALL_SIZE / 2);

  // P1 event detection on the current positions
  assign hit_left_p1  = (dir_x == DIR_LEFT) &&
                        (ball_x <= X_W'(LEFT_PAD_X + PAD_W)) &&
                        (ball_x + X_W'(BALL_SIZE) > X_W'(LEFT_PAD_X)) &&
                        y_covered(ball_cy, pad_left_y);
  assign hit_right_p1 = (dir_x == DIR_RIGHT) &&
                        (ball_x + X_W'(BALL_SIZE) >= X_W'(RIGHT_PAD_X)) &&
                        (ball_x < X_W'(RIGHT_PAD_X + PAD_W)) &&
                        y_covered(ball_cy, pad_right_y);
  assign hit_p1        = hit_left_p1 | hit_right_p1;
  assign goal_left_p1  = !hit_p1 && (dir_x == DIR_RIGHT) &&
                         (ball_x >= X_W'(SCREEN_W - BALL_SIZE) - speed_x);
  assign goal_right_p1 = !hit_p1 && (dir_x == DIR_LEFT) && (ball_x < speed_x);
  assign wall_p1       = ((dir_y == DIR_UP) && (ball_y < speed_y)) ||
                         ((dir_y == DIR_DOWN) && (ball_y >= Y_W'(SCREEN_H - BALL_SIZE) - speed_y));

  assign point_wins = scorer_left ? (score_left + 4'd1 == WIN) : (score_right + 4'd1 == WIN);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= PH_P0;
      busy        <= 1'b0;
      dir_x       <= DIR_RIGHT;
      dir_y       <= DIR_UP;
      scorer_left <= 1'b0;
      serve_cnt   <= '0;
      ball_x      <= CENTRE_X;
      ball_y      <= CENTRE_Y;
      pad_left_y  <= '0;
      pad_right_y <= '0;
      score_left  <= '0;
      score_right <= '0;
    end else begin
      if (busy) begin
        case (phase)
          // P0: paddle registers
          PH_P0: begin
            pad_left_y  <= pad_left_nxt;
            pad_right_y <= pad_right_nxt;
            phase       <= PH_P1;
          end
          // P1: direction updates and goal detection
          PH_P1: begin
            if (state == ST_PLAY) begin
              if (hit_p1)  dir_x <= ~dir_x;
              if (wall_p1) dir_y <= ~dir_y;
              if (goal_left_p1 || goal_right_p1) begin
                state       <= ST_POINT;
                scorer_left <= goal_left_p1;
              end
            end
            phase <= PH_P2;
          end
          // P2: ball step, or serve countdown
          default: begin
            busy  <= 1'b0;
            phase <= PH_P0;
            if (state == ST_PLAY) begin
              ball_x <= (dir_x == DIR_RIGHT) ? ball_x + speed_x : ball_x - speed_x;
              ball_y <= (dir_y == DIR_DOWN)  ? ball_y + speed_y : ball_y - speed_y;
            end else if (state == ST_SERVE) begin
              if (serve_cnt == CNT_W'(SERVE_TICKS - 1)) begin
                serve_cnt <= '0;
                state     <= ST_PLAY;
              end else begin
                serve_cnt <= serve_cnt + 1'b1;
              end
            end
          end
        endcase
      end else if (tick && (state == ST_SERVE || state == ST_PLAY)) begin
        busy <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score_left  <= '0;
            score_right <= '0;
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            serve_cnt   <= '0;
            state       <= ST_SERVE;
          end
        end
        ST_POINT: begin
          // Serve goes toward the player who just conceded
          if (scorer_left) begin
            score_left <= score_left + 4'd1;
            dir_x      <= DIR_RIGHT;
          end else begin
            score_right <= score_right + 4'd1;
            dir_x       <= DIR_LEFT;
          end
          dir_y <= DIR_UP;
          if (point_wins) begin
            state <= ST_OVER;
          end else begin
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            serve_cnt <= '0;
            state     <= ST_SERVE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: paddle mapping, serve timing, wall and
// paddle bounces, goals, game over, dropped ticks and async reset.
module tb_pong_game_engine;

  logic        board_clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        start;
  logic [7:0]  pot_left;
  logic [7:0]  pot_right;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [9:0]  pad_left_y;
  logic [9:0]  pad_right_y;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic [2:0]  game_state;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  pong_game_engine dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .pot_left   (pot_left),
    .pot_right  (pot_right),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pad_left_y (pad_left_y),
    .pad_right_y(pad_right_y),
    .score_left (score_left),
    .score_right(score_right),
    .game_state (game_state),
    .busy       (busy)
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted tick: strobe, then the three phase cycles; returns with outputs settled.
  task automatic do_tick();
    tick = 1'b1;
    @(posedge board_clk);
    #1 tick = 1'b0;
    repeat (3) @(posedge board_clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    pot_left = 8'd0; pot_right = 8'd255;
    repeat (2) @(posedge board_clk);
    #1;
    check("rst_ball_x", ball_x, 315);
    check("rst_ball_y", ball_y, 235);
    check("rst_pad_l", pad_left_y, 0);
    check("rst_pad_r", pad_right_y, 0);
    check("rst_score_l", score_left, 0);
    check("rst_score_r", score_right, 0);
    check("rst_state", game_state, 0);
    check("rst_busy", busy, 0);
    @(negedge board_clk) reset = 1'b0;

    // tick in IDLE is ignored
    tick = 1'b1;
    @(posedge board_clk);
    #1 tick = 1'b0;
    check("idle_tick_busy", busy, 0);
    check("idle_state", game_state, 0);

    start = 1'b1;
    @(posedge board_clk);
    #1 start = 1'b0;
    check("start_state", game_state, 1);
    check("start_score_l", score_left, 0);

    // paddle mapping during SERVE (serve ticks 1..5)
    pot_left = 8'd100;
    tick = 1'b1;
    @(posedge board_clk);
    #1 tick = 1'b0;
    check("busy_set", busy, 1);
    repeat (3) @(posedge board_clk);
    #1;
    check("busy_clear", busy, 0);
    check("pad_l_100", pad_left_y, 159);
    check("pad_r_255", pad_right_y, 430);
    pot_left = 8'd255; do_tick(); check("pad_l_255", pad_left_y, 430);
    pot_left = 8'd0;   do_tick(); check("pad_l_0", pad_left_y, 0);
    pot_left = 8'd20;  do_tick(); check("pad_l_deadzone", pad_left_y, 0);
    pot_left = 8'd255; do_tick(); check("pad_l_back", pad_left_y, 430);

    run_ticks(54);
    check("serve59_state", game_state, 1);
    check("serve59_x", ball_x, 315);
    do_tick();
    check("play_state", game_state, 2);
    check("play_x0", ball_x, 315);
    check("play_y0", ball_y, 235);

    do_tick();
    check("mv1_x", ball_x, 317);
    check("mv1_y", ball_y, 233);

    // start is ignored in PLAY
    start = 1'b1;
    do_tick();
    start = 1'b0;
    check("start_play_state", game_state, 2);
    check("mv2_x", ball_x, 319);
    check("mv2_y", ball_y, 231);

    run_ticks(115);
    check("top_x", ball_x, 549);
    check("top_y", ball_y, 1);
    do_tick();
    check("wall_x", ball_x, 551);
    check("wall_y", ball_y, 3);

    // tick held through a busy cycle moves the ball only once
    tick = 1'b1;
    @(posedge board_clk);
    #1;
    @(posedge board_clk);
    #1 tick = 1'b0;
    repeat (2) @(posedge board_clk);
    #1;
    check("drop_x", ball_x, 553);
    check("drop_y", ball_y, 5);
    @(posedge board_clk);
    #1;
    check("drop_busy", busy, 0);
    check("drop_x_hold", ball_x, 553);

    run_ticks(38);
    check("edge_x", ball_x, 629);
    check("edge_y", ball_y, 81);
    do_tick();
    check("goalL_score_l", score_left, 1);
    check("goalL_score_r", score_right, 0);
    check("goalL_state", game_state, 1);
    check("goalL_x", ball_x, 315);
    check("goalL_y", ball_y, 235);

    // second serve goes right (toward the conceding right player)
    run_ticks(60);
    do_tick();
    check("serve2_x", ball_x, 317);
    check("serve2_y", ball_y, 233);
    run_ticks(137);
    check("pre_hit_x", ball_x, 591);
    check("pre_hit_y", ball_y, 43);
    pot_right = 8'd0;
    do_tick();
    check("hit_pad_r", pad_right_y, 0);
    check("hit_x", ball_x, 589);
    check("hit_y", ball_y, 45);
    check("hit_score_l", score_left, 1);
    check("hit_state", game_state, 2);
    pot_right = 8'd255;

    run_ticks(294);
    check("left_edge_x", ball_x, 1);
    check("left_edge_y", ball_y, 305);
    do_tick();
    check("goalR1_score_r", score_right, 1);
    check("goalR1_state", game_state, 1);

    // serve goes left (toward the conceding left player)
    run_ticks(60);
    do_tick();
    check("serve3_x", ball_x, 313);
    check("serve3_y", ball_y, 233);
    run_ticks(157);
    check("goalR2_score_r", score_right, 2);

    for (int k = 3; k <= 9; k++) begin
      run_ticks(218);
      check($sformatf("goalR%0d_score_r", k), score_right, k);
    end
    check("over_state", game_state, 4);
    check("over_score_l", score_left, 1);
    check("over_x", ball_x, 1);
    check("over_y", ball_y, 81);

    tick = 1'b1;
    @(posedge board_clk);
    #1 tick = 1'b0;
    check("over_tick_busy", busy, 0);

    start = 1'b1;
    @(posedge board_clk);
    #1 start = 1'b0;
    check("restart_state", game_state, 1);
    check("restart_score_l", score_left, 0);
    check("restart_score_r", score_right, 0);

    // async reset in the middle of a tick sequence
    pot_left = 8'd100;
    tick = 1'b1;
    @(posedge board_clk);
    #1 tick = 1'b0;
    @(posedge board_clk);
    #1;
    check("mid_busy", busy, 1);
    check("mid_pad_l", pad_left_y, 159);
    @(negedge board_clk) reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_state", game_state, 0);
    check("arst_pad_l", pad_left_y, 0);
    check("arst_pad_r", pad_right_y, 0);
    check("arst_x", ball_x, 315);
    check("arst_y", ball_y, 235);
    @(negedge board_clk) reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
